// File: rtl/bf_pkg.sv
// Shared constants for the BF machine: arbiter states, read-owner codes, opcodes.
package bf_pkg;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  // Which port a returning read belongs to
  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DBG  = 1'b1;

  // BF opcodes, ASCII-encoded as they appear in program memory
  localparam logic [7:0] OP_INC_PTR = 8'h3E; // '>'
  localparam logic [7:0] OP_DEC_PTR = 8'h3C; // '<'
  localparam logic [7:0] OP_INC     = 8'h2B; // '+'
  localparam logic [7:0] OP_DEC     = 8'h2D; // '-'
  localparam logic [7:0] OP_OUT     = 8'h2E; // '.'
  localparam logic [7:0] OP_IN      = 8'h2C; // ','
  localparam logic [7:0] OP_JZ      = 8'h5B; // '['
  localparam logic [7:0] OP_JNZ     = 8'h5D; // ']'

endpackage

// File: rtl/bf_data_mem_arbiter_if.sv
// Request/return signals of the core and debug ports plus the memory bus.
interface bf_data_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Requesters and the memory model
  modport master (
    output core_req, core_we, core_addr, core_wdata, dbg_req, dbg_addr, mem_rdata,
    input  core_gnt, core_rvalid, core_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_addr, mem_wdata, mem_we
  );

  // The arbiter
  modport slave (
    input  core_req, core_we, core_addr, core_wdata, dbg_req, dbg_addr, mem_rdata,
    output core_gnt, core_rvalid, core_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/bf_mem_clear_seq.sv
// Address counter for the memory clear sweep; pulses done on the last cell.
module bf_mem_clear_seq
  import bf_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  output logic [ADDR_W-1:0] cnt_o,
  output logic              done_o
);

  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Advance while clearing; natural overflow wraps back to 0 after the last cell
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign done_o = en_i && (cnt_q == {ADDR_W{1'b1}});

endmodule

// File: rtl/bf_data_mem_arbiter.sv
// Data-memory owner: clears the tape after reset/on request, then arbitrates
// core read/modify/write and debug reads with a starvation guard for debug.
module bf_data_mem_arbiter
  import bf_pkg::*;
#(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  clear_done,
  bf_data_mem_arbiter_if.slave  bus
);

  localparam int unsigned     StarveW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  state_e              state_q, state_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_owner_q, rd_owner_d;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   core_rdata_q, dbg_rdata_q;
  logic [ADDR_W-1:0]   clr_cnt;
  logic                clr_done;
  logic                core_gnt, dbg_gnt, mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata, core_rdata, dbg_rdata;
  logic                core_rvalid, dbg_rvalid;

  bf_mem_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk    (clk),
    .reset  (reset),
    .en_i   (state_q == S_CLEAR),
    .cnt_o  (clr_cnt),
    .done_o (clr_done)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  // Next state: one idle cycle, full sweep, then run until a clear is requested
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:  state_d = S_CLEAR;
      S_CLEAR: if (clr_done) state_d = S_RUN;
      S_RUN:   if (clear_req) state_d = S_CLEAR;
      default: state_d = S_INIT;
    endcase
  end

  // Outputs: clear writes, or the arbitration winner drives the memory bus
  always_comb begin
    busy       = 1'b1;
    clear_done = 1'b0;
    core_gnt   = 1'b0;
    dbg_gnt    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = mem_addr_q;
    mem_wdata  = '0;
    unique case (state_q)
      S_CLEAR: begin
        mem_we     = 1'b1;
        mem_addr   = clr_cnt;
        clear_done = clr_done;
      end
      S_RUN: begin
        busy = 1'b0;
        // A clear request suppresses every grant in its own cycle
        if (!clear_req) begin
          if (bus.dbg_req && (starve_q >= StarveMax)) dbg_gnt  = 1'b1;
          else if (bus.core_req)                      core_gnt = 1'b1;
          else if (bus.dbg_req)                       dbg_gnt  = 1'b1;
        end
        if (core_gnt) begin
          mem_addr = bus.core_addr;
          mem_we   = bus.core_we;
          if (bus.core_we) mem_wdata = bus.core_wdata;
        end
        if (dbg_gnt) mem_addr = bus.dbg_addr;
      end
      default: ;
    endcase
  end

  // Starvation counter and read-owner pipeline next state
  always_comb begin
    starve_d = starve_q;
    if (state_q == S_RUN) begin
      if (clear_req || dbg_gnt) starve_d = '0;
      else if (bus.dbg_req && (starve_q < StarveMax)) starve_d = starve_q + 1'b1;
    end
    rd_valid_d = (core_gnt && !bus.core_we) || dbg_gnt;
    rd_owner_d = dbg_gnt ? OWN_DBG : OWN_CORE;
  end

  // Return path: the owner sees the memory data, the other port keeps its last value
  always_comb begin
    core_rvalid = rd_valid_q && (rd_owner_q == OWN_CORE);
    dbg_rvalid  = rd_valid_q && (rd_owner_q == OWN_DBG);
    core_rdata  = core_rvalid ? bus.mem_rdata : core_rdata_q;
    dbg_rdata   = dbg_rvalid  ? bus.mem_rdata : dbg_rdata_q;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q     <= '0;
      rd_valid_q   <= 1'b0;
      rd_owner_q   <= OWN_CORE;
      mem_addr_q   <= '0;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      starve_q     <= starve_d;
      rd_valid_q   <= rd_valid_d;
      rd_owner_q   <= rd_owner_d;
      mem_addr_q   <= mem_addr;
      core_rdata_q <= core_rdata;
      dbg_rdata_q  <= dbg_rdata;
    end
  end

  assign bus.core_gnt    = core_gnt;
  assign bus.dbg_gnt     = dbg_gnt;
  assign bus.core_rvalid = core_rvalid;
  assign bus.dbg_rvalid  = dbg_rvalid;
  assign bus.core_rdata  = core_rdata;
  assign bus.dbg_rdata   = dbg_rdata;
  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;

endmodule

// File: tb/tb_bf_data_mem_arbiter.sv
// Bench for bf_data_mem_arbiter: table vectors, hand sequences and random traffic,
// all checked against a cycle-level behavioural model with a shadow memory.
module tb_bf_data_mem_arbiter;
  import bf_pkg::*;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned LIMIT = 3;
  localparam int unsigned DEPTH = 16;
  localparam int PH_INIT = 0;
  localparam int PH_CLEAR = 1;
  localparam int PH_RUN = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear_req = 1'b0;
  logic busy, clear_done;

  bf_data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bf_data_mem_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear_req  (clear_req),
    .busy       (busy),
    .clear_done (clear_done),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  // Synchronous write-first memory
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= bus.mem_we ? bus.mem_wdata : mem[bus.mem_addr];
  end

  // Reference model state
  int            m_phase, m_idx, m_denied;
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] sh_mem [DEPTH];
  bit            m_pend;
  logic          m_pend_own;
  logic [DW-1:0] m_pend_data, m_core_rd, m_dbg_rd;
  bit            e_cg, e_dg;

  // Values sampled by the last step
  bit            s_busy, s_done, s_we, s_cg, s_dg, s_crv, s_drv;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_crd, s_drd;

  int n_pass = 0;
  int n_total = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic void m_reset();
    m_phase = PH_INIT;
    m_idx = 0;
    m_denied = 0;
    m_last_addr = '0;
    m_pend = 0;
    m_core_rd = '0;
    m_dbg_rd = '0;
  endfunction

  // One clock cycle: predict, compare at the falling edge, advance the model
  task automatic step();
    bit x_busy, x_done, x_cg, x_dg, x_we, x_crv, x_drv;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_wd;
    @(negedge clk);
    x_cg = 0; x_dg = 0; x_we = 0; x_wd = '0; x_done = 0;
    x_addr = m_last_addr;
    x_busy = (m_phase != PH_RUN);
    x_crv = m_pend && (m_pend_own == OWN_CORE);
    x_drv = m_pend && (m_pend_own == OWN_DBG);
    if (x_crv) m_core_rd = m_pend_data;
    if (x_drv) m_dbg_rd = m_pend_data;
    if (m_phase == PH_CLEAR) begin
      x_we = 1; x_addr = AW'(m_idx); x_done = (m_idx == DEPTH - 1);
    end else if (m_phase == PH_RUN && !clear_req) begin
      if (bus.dbg_req && (m_denied >= int'(LIMIT) || !bus.core_req)) x_dg = 1;
      else if (bus.core_req) x_cg = 1;
      if (x_cg) begin
        x_addr = bus.core_addr; x_we = bus.core_we;
        if (bus.core_we) x_wd = bus.core_wdata;
      end
      if (x_dg) x_addr = bus.dbg_addr;
    end
    s_busy = busy; s_done = clear_done; s_we = bus.mem_we; s_addr = bus.mem_addr;
    s_cg = bus.core_gnt; s_dg = bus.dbg_gnt; s_crv = bus.core_rvalid; s_drv = bus.dbg_rvalid;
    s_crd = bus.core_rdata; s_drd = bus.dbg_rdata;
    chk("busy", 32'(busy), 32'(x_busy));
    chk("clear_done", 32'(clear_done), 32'(x_done));
    chk("core_gnt", 32'(bus.core_gnt), 32'(x_cg));
    chk("dbg_gnt", 32'(bus.dbg_gnt), 32'(x_dg));
    chk("mem_we", 32'(bus.mem_we), 32'(x_we));
    chk("mem_addr", 32'(bus.mem_addr), 32'(x_addr));
    if (x_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(x_wd));
    chk("core_rvalid", 32'(bus.core_rvalid), 32'(x_crv));
    chk("dbg_rvalid", 32'(bus.dbg_rvalid), 32'(x_drv));
    chk("core_rdata", 32'(bus.core_rdata), 32'(m_core_rd));
    chk("dbg_rdata", 32'(bus.dbg_rdata), 32'(m_dbg_rd));
    // Advance the model
    m_pend = 0;
    if (x_we) sh_mem[x_addr] = x_wd;
    if ((x_cg && !bus.core_we) || x_dg) begin
      m_pend = 1;
      m_pend_own = x_dg ? OWN_DBG : OWN_CORE;
      m_pend_data = sh_mem[x_addr];
    end
    m_last_addr = x_addr;
    e_cg = x_cg; e_dg = x_dg;
    case (m_phase)
      PH_INIT: m_phase = PH_CLEAR;
      PH_CLEAR: begin
        if (m_idx == DEPTH - 1) begin m_idx = 0; m_phase = PH_RUN; end
        else m_idx++;
      end
      default: begin
        if (clear_req) begin m_phase = PH_CLEAR; m_denied = 0; end
        else if (x_dg) m_denied = 0;
        else if (bus.dbg_req) m_denied++;
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(bit req, bit we, int addr, int wd);
    bus.core_req = req; bus.core_we = we;
    bus.core_addr = AW'(addr); bus.core_wdata = DW'(wd);
  endtask

  task automatic set_dbg(bit req, int addr);
    bus.dbg_req = req; bus.dbg_addr = AW'(addr);
  endtask

  typedef struct {
    bit            c_req, c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wd;
    bit            d_req;
    logic [AW-1:0] d_addr;
    bit            e_cg, e_dg, e_crv, e_drv;
    logic [DW-1:0] e_rd;
  } vec_t;

  vec_t vt [9];

  initial begin
    int busy_n, done_n, gnt_n, we_n;
    logic [AW-1:0] done_addr;
    logic [DEPTH-1:0] seen;
    bit c_hold, d_hold;

    //        c_req we addr wdata  d_req addr  cg dg crv drv rdata
    vt[0] = '{1, 1, 4'd3, 8'h2A, 0, 4'd0, 1, 0, 0, 0, 8'h00};
    vt[1] = '{1, 0, 4'd3, 8'h00, 0, 4'd0, 1, 0, 0, 0, 8'h00};
    vt[2] = '{0, 0, 4'd0, 8'h00, 0, 4'd0, 0, 0, 1, 0, 8'h2A};
    vt[3] = '{1, 0, 4'd3, 8'h00, 1, 4'd3, 1, 0, 0, 0, 8'h00};
    vt[4] = '{1, 0, 4'd3, 8'h00, 1, 4'd3, 1, 0, 1, 0, 8'h2A};
    vt[5] = '{1, 0, 4'd3, 8'h00, 1, 4'd3, 1, 0, 1, 0, 8'h2A};
    vt[6] = '{1, 0, 4'd3, 8'h00, 1, 4'd3, 0, 1, 1, 0, 8'h2A};
    vt[7] = '{1, 0, 4'd3, 8'h00, 1, 4'd3, 1, 0, 0, 1, 8'h2A};
    vt[8] = '{0, 0, 4'd0, 8'h00, 0, 4'd0, 0, 0, 1, 0, 8'h2A};

    for (int i = 0; i < int'(DEPTH); i++) begin mem[i] = 8'hA5; sh_mem[i] = 8'hA5; end
    set_core(0, 0, 0, 0);
    set_dbg(0, 0);

    // Reset: outputs forced quiet asynchronously
    #2 reset = 1'b1;
    #10;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_gnts", 32'({bus.core_gnt, bus.dbg_gnt}), 32'd0);
    chk("rst_rvalids", 32'({bus.core_rvalid, bus.dbg_rvalid}), 32'd0);
    chk("rst_clear_done", 32'(clear_done), 32'd0);

    // Release: 1 init cycle + 16 clear cycles, core request held throughout
    @(posedge clk); #1;
    reset = 1'b0;
    m_reset();
    set_core(1, 0, 0, 0);
    busy_n = 0; done_n = 0; gnt_n = 0; done_addr = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_busy) begin busy_n++; if (s_cg) gnt_n++; end
      if (s_done) begin done_n++; done_addr = s_addr; end
      if (e_cg) bus.core_req = 1'b0;
    end
    chk("init_busy_cycles", 32'(busy_n), 32'd17);
    chk("init_done_pulses", 32'(done_n), 32'd1);
    chk("init_done_addr", 32'(done_addr), 32'd15);
    chk("init_no_core_gnt", 32'(gnt_n), 32'd0);
    set_core(0, 0, 0, 0);
    step();

    // Table: write/read-back and the debug starvation guard
    for (int i = 0; i < 9; i++) begin
      set_core(vt[i].c_req, vt[i].c_we, int'(vt[i].c_addr), int'(vt[i].c_wd));
      set_dbg(vt[i].d_req, int'(vt[i].d_addr));
      step();
      chk($sformatf("vec%0d_core_gnt", i), 32'(s_cg), 32'(vt[i].e_cg));
      chk($sformatf("vec%0d_dbg_gnt", i), 32'(s_dg), 32'(vt[i].e_dg));
      chk($sformatf("vec%0d_core_rvalid", i), 32'(s_crv), 32'(vt[i].e_crv));
      chk($sformatf("vec%0d_dbg_rvalid", i), 32'(s_drv), 32'(vt[i].e_drv));
      if (vt[i].e_crv) chk($sformatf("vec%0d_core_rdata", i), 32'(s_crd), 32'(vt[i].e_rd));
      if (vt[i].e_drv) chk($sformatf("vec%0d_dbg_rdata", i), 32'(s_drd), 32'(vt[i].e_rd));
    end

    // Read in flight when a clear is requested still completes
    set_core(1, 1, 5, 8'h77); step();
    set_core(1, 0, 5, 0); step();
    chk("rdclr_gnt", 32'(s_cg), 32'd1);
    set_core(0, 0, 0, 0); clear_req = 1'b1; step();
    chk("rdclr_rvalid", 32'(s_crv), 32'd1);
    chk("rdclr_rdata", 32'(s_crd), 32'h77);
    chk("rdclr_no_gnt", 32'({s_cg, s_dg}), 32'd0);
    clear_req = 1'b0;
    set_core(1, 0, 5, 0); set_dbg(1, 5);
    gnt_n = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (s_cg || s_dg) gnt_n++;
    end
    chk("rdclr_grants_in_clear", 32'(gnt_n), 32'd0);
    step();
    chk("rdclr_core_first", 32'(s_cg), 32'd1);
    set_core(0, 0, 0, 0); step();
    chk("rdclr_addr5_zero_v", 32'(s_crv), 32'd1);
    chk("rdclr_addr5_zero", 32'(s_crd), 32'd0);
    set_dbg(0, 0); step();
    chk("rdclr_dbg_addr5", 32'(s_drd), 32'd0);

    // Reset in the middle of a clear restarts the sweep from address 0
    clear_req = 1'b1; step();
    clear_req = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("midrst_addr_before", 32'(bus.mem_addr), 32'd7);
    reset = 1'b1;
    #1;
    chk("midrst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    m_reset();
    seen = '0; we_n = 0; done_n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_we) begin we_n++; seen[s_addr] = 1'b1; end
      if (s_done) done_n++;
    end
    chk("midrst_writes", 32'(we_n), 32'd16);
    chk("midrst_all_cells", 32'(seen), 32'(16'hFFFF));
    chk("midrst_done", 32'(done_n), 32'd1);

    // Clear requests during a clear are ignored
    clear_req = 1'b1;
    done_n = 0; busy_n = 0;
    for (int i = 0; i < 22; i++) begin
      if (i == 6) clear_req = 1'b0;
      step();
      if (s_done) done_n++;
      if (s_busy) busy_n++;
    end
    chk("clrclr_done", 32'(done_n), 32'd1);
    chk("clrclr_busy", 32'(busy_n), 32'd16);

    // Random traffic against the model
    c_hold = 0; d_hold = 0;
    for (int i = 0; i < 500; i++) begin
      if (!c_hold) begin
        if ($urandom_range(0, 9) < 6) begin
          set_core(1, bit'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                   int'($urandom_range(0, 255)));
          c_hold = 1;
        end else bus.core_req = 1'b0;
      end
      if (!d_hold) begin
        if ($urandom_range(0, 1) == 1) begin
          set_dbg(1, int'($urandom_range(0, DEPTH - 1)));
          d_hold = 1;
        end else bus.dbg_req = 1'b0;
      end
      clear_req = ($urandom_range(0, 63) == 0);
      step();
      if (e_cg) c_hold = 0;
      if (e_dg) d_hold = 0;
    end
    clear_req = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bf_data_mem_arbiter.md
Name: bf_data_mem_arbiter

Overview:
- Owns the single-port data memory (tape) of the BF machine and shares it between three users: the internal clear engine, the BF core datapath (read/modify/write of the cell under the data pointer), and a debug/display reader.
- Replaces ad-hoc memory zeroing in the core: after reset, and on request, it zeroes every cell before the core may run.
- Arbitration: fixed priority with a starvation guard for the debug port.

Parameters:
- ADDR_W, 8, data memory address width; DEPTH = 2**ADDR_W cells.
- DATA_W, 8, cell width.
- STARVE_LIMIT, 15, consecutive denied debug cycles before debug is granted over core; minimum 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clear_req  in  1  pulse: start a full memory clear.
- busy  out  1  high during S_INIT and S_CLEAR.
- clear_done  out  1  one-cycle pulse when the last cell has been written.
- core_req  in  1  core access request.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  ADDR_W  core address.
- core_wdata  in  DATA_W  core write data.
- core_gnt  out  1  combinational; access issued this cycle.
- core_rvalid  out  1  read data valid for core.
- core_rdata  out  DATA_W  read data.
- dbg_req  in  1  debug read request.
- dbg_addr  in  ADDR_W  debug address.
- dbg_gnt  out  1  combinational grant.
- dbg_rvalid  out  1  read data valid for debug.
- dbg_rdata  out  DATA_W  read data.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after the address (synchronous read).

Behaviour:
- States: S_INIT, S_CLEAR, S_RUN.
- reset asserted: state = S_INIT, clr_cnt = 0, starve_cnt = 0, read-owner pipeline cleared.
- Outputs under reset: mem_we = 0, mem_addr = 0, mem_wdata = 0, both gnt = 0, both rvalid = 0, clear_done = 0, busy = 1.
- S_INIT: lasts exactly one cycle, no memory access, then S_CLEAR.
- S_CLEAR, each cycle:
  - Drives mem_we = 1, mem_addr = clr_cnt, mem_wdata = 0; no grants.
  - clr_cnt increments each cycle.
  - At clr_cnt = DEPTH-1: clear_done pulses in that same cycle, clr_cnt wraps to 0, next state is S_RUN.
  - A full clear takes DEPTH cycles. clear_req is ignored in S_CLEAR.
- S_RUN:
  - clear_req = 1 goes to S_CLEAR next cycle. No grant is issued in the clear_req cycle, even if core_req or dbg_req is high.
  - Otherwise the winner is chosen combinationally each cycle:
    - debug wins if starve_cnt >= STARVE_LIMIT and dbg_req;
    - else core wins if core_req;
    - else debug wins if dbg_req.
  - At most one gnt per cycle. mem_* are driven from the winner's fields; debug never writes.
  - With no winner: mem_we = 0, mem_addr holds its last value, mem_wdata = 0.
- Read return:
  - A granted read sets a one-bit owner register plus a valid register.
  - The next cycle, the owner's rvalid = 1 and its rdata = mem_rdata. The other port's rdata holds its previous value.
  - Latency from gnt to rvalid is 1 cycle. Back-to-back reads are fully pipelined.
  - A granted write produces no rvalid.
- Read completion across a clear: a read granted in the last S_RUN cycle before a clear_req-driven clear still returns rvalid in the first S_CLEAR cycle.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, in S_RUN cycles where dbg_req = 1 and dbg_gnt = 0.
  - Clears on any dbg_gnt.
  - Clears on entry to S_CLEAR.
- Requesters must hold req and their fields stable until gnt. A requester that drops req before gnt gets no grant.
- Write/read to the same address in consecutive cycles: the read returns the newly written value (memory is write-first). The arbiter adds no forwarding.

Decomposition:
- Shared package bf_pkg holds:
  - state encodings S_INIT/S_CLEAR/S_RUN;
  - owner encodings OWN_CORE = 0, OWN_DBG = 1;
  - the BF opcode constants shared with the core control FSM.
- One natural sub-module: bf_mem_clear_seq, covering the clr_cnt counter, the wrap, and the clear_done pulse. The arbitration and return pipeline stay in the top module.

Test Plan:
- Reset release, ADDR_W = 4: busy stays high for 1 + 16 cycles; mem_we = 1 with addr 0..15 and wdata 0; clear_done pulses with addr 15; core_gnt = 0 throughout.
- S_RUN, core writes 0x2A to addr 3, then reads addr 3: core_gnt in both cycles; core_rvalid = 1 with core_rdata = 0x2A one cycle after the read grant.
- core_req and dbg_req held continuously, STARVE_LIMIT = 3: grant sequence is core, core, core, dbg, core… with dbg_rvalid one cycle after each dbg_gnt.
- core read of addr 5 granted, clear_req pulsed next cycle: core_rvalid still returns in the first S_CLEAR cycle; no grants for 16 cycles; addr 5 then reads 0.
- reset asserted mid-clear (clr_cnt = 7): mem_we drops to 0 immediately (asynchronously); after release, the clear restarts at addr 0 and completes with all 16 cells written.
- clear_req pulsed during S_CLEAR: ignored; exactly one clear_done pulse.
